sdram_arbit: RTL and testbench
==============================

SDRAM_ARBIT -- requirements
Module: sdram_arbit

Interface
REQ-001 The block SHALL use reset s_rst_n, asynchronous, active-low; clock sclk.
REQ-002 The block SHALL have these ports, all single-bit unless a width is given:
- sclk, input, 1: system clock.
- s_rst_n, input, 1: asynchronous active-low reset.
- init_end, input, 1: power-up init done; level, stays high.
- init_cmd / init_addr, input, 4/12: init-stage command and address.
- ref_req / ref_end, input, 1/1: auto-refresh request (level) and done pulse.
- ref_cmd / ref_addr, input, 4/12: refresh-stage command and address.
- wr_req / wr_end, input, 1/1: write request (level) and done pulse.
- wr_cmd / wr_addr / wr_bank / wr_data, input, 4/12/2/16: write-stage bus.
- rd_req / rd_end, input, 1/1: read request (level) and done pulse.
- rd_cmd / rd_addr / rd_bank, input, 4/12/2: read-stage bus.
- ref_en / wr_en / rd_en, output, 1/1/1: grants, one-hot or all zero.
- sdram_cmd, output, 4: {cs_n, ras_n, cas_n, we_n}.
- sdram_addr / sdram_bank, output, 12/2: address and bank to SDRAM.
- sdram_dq_out / sdram_dq_oe, output, 16/1: write data and tristate enable.
- arb_err, output, 1: watchdog fault pulse.

Function
REQ-003 The block SHALL use command encodings NOP=0111, PRE=0010, AREF=0001, ACT=0011, RD=0101, WR=0100.
REQ-004 The state machine SHALL have states INIT, ARBIT, AREF, WRITE, READ, one-hot encoded; an illegal encoding SHALL go to INIT.
REQ-005 INIT SHALL go to ARBIT in the cycle after init_end is sampled high.
REQ-006 ARBIT SHALL use fixed priority ref_req > wr_req > rd_req: go to AREF, WRITE or READ next cycle; with no request, stay in ARBIT.
REQ-007 AREF, WRITE and READ SHALL return to ARBIT on ref_end, wr_end or rd_end respectively; requests SHALL NOT be sampled outside ARBIT.
REQ-008 Each owner SHALL keep ownership until its own end pulse, even if a higher-priority request arrives meanwhile (no preemption; the read/write stages yield to refresh themselves).
REQ-009 ref_en, wr_en and rd_en SHALL be Moore decodes of state: high exactly while in AREF, WRITE or READ respectively.
REQ-010 The sdram_cmd/addr/bank mux SHALL be combinational on state:
- INIT: init_cmd, init_addr, bank 00.
- AREF: ref_cmd, ref_addr, bank 00.
- WRITE: wr_* signals.
- READ: rd_* signals.
- ARBIT: NOP, address 0, bank 00.
REQ-011 sdram_dq_out SHALL equal wr_data; sdram_dq_oe SHALL be 1 only in WRITE.
REQ-012 An end pulse for a non-owning stage SHALL be ignored.
REQ-013 After an end pulse, there SHALL be at least one ARBIT cycle (NOP) before the next grant.

Reset
REQ-014 On s_rst_n low, the state SHALL be INIT. Outputs: en signals 0, sdram_cmd = init_cmd passthrough, arb_err 0, watchdog counter 0.
REQ-015 Reset asserted mid-grant SHALL drop all grants in the same cycle (asynchronous); after release, the block SHALL wait for init_end again.

Configuration
REQ-016 With macro SDRAM_ARBIT_WDT_EN defined, a 12-bit counter SHALL count cycles spent in AREF/WRITE/READ and clear in any other state.
- On reaching 4095 without an end pulse: go to ARBIT, pulse arb_err high for one cycle, drop the grant.
REQ-017 Without SDRAM_ARBIT_WDT_EN, no counter SHALL exist, arb_err SHALL be tied 0, and grants SHALL be held indefinitely.

Verification
REQ-018 Reset, init_end high at cycle 10 -> INIT until cycle 11, then ARBIT with sdram_cmd=0111 and all en=0.
REQ-019 ref_req, wr_req and rd_req all high in the same ARBIT cycle -> ref_en=1 next cycle; after ref_end, one NOP cycle, then wr_en=1; rd_en only after wr_end.
REQ-020 In READ with rd_cmd=0101, rd_addr=0x1FF -> sdram_cmd=0101, sdram_addr=0x1FF, sdram_dq_oe=0; ref_req rising mid-read -> rd_en stays 1 until rd_end.
REQ-021 In WRITE with wr_data=0xA5A5 -> sdram_dq_out=0xA5A5, sdram_dq_oe=1; wr_end -> oe=0 the next cycle.
REQ-022 In READ, a spurious wr_end pulse -> no state change; s_rst_n pulsed low -> rd_en=0 immediately, state INIT.
REQ-023 With SDRAM_ARBIT_WDT_EN, grant READ and withhold rd_end -> after 4095 cycles, arb_err is a 1-cycle pulse, state ARBIT, rd_en=0; without the macro, rd_en stays 1.

Source files
------------

// File: rtl/sdram_arbit_if.sv
// Bus bundle between the SDRAM stage controllers (init/refresh/write/read) and the arbiter.
// slave: arbiter side; master: stage/SDRAM side.
interface sdram_arbit_if;
    logic        init_end;
    logic [3:0]  init_cmd;
    logic [11:0] init_addr;
    logic        ref_req;
    logic        ref_end;
    logic [3:0]  ref_cmd;
    logic [11:0] ref_addr;
    logic        wr_req;
    logic        wr_end;
    logic [3:0]  wr_cmd;
    logic [11:0] wr_addr;
    logic [1:0]  wr_bank;
    logic [15:0] wr_data;
    logic        rd_req;
    logic        rd_end;
    logic [3:0]  rd_cmd;
    logic [11:0] rd_addr;
    logic [1:0]  rd_bank;
    logic        ref_en;
    logic        wr_en;
    logic        rd_en;
    logic [3:0]  sdram_cmd;
    logic [11:0] sdram_addr;
    logic [1:0]  sdram_bank;
    logic [15:0] sdram_dq_out;
    logic        sdram_dq_oe;
    logic        arb_err;

    modport slave (
        input  init_end, init_cmd, init_addr,
        input  ref_req, ref_end, ref_cmd, ref_addr,
        input  wr_req, wr_end, wr_cmd, wr_addr, wr_bank, wr_data,
        input  rd_req, rd_end, rd_cmd, rd_addr, rd_bank,
        output ref_en, wr_en, rd_en,
        output sdram_cmd, sdram_addr, sdram_bank, sdram_dq_out, sdram_dq_oe,
        output arb_err
    );

    modport master (
        output init_end, init_cmd, init_addr,
        output ref_req, ref_end, ref_cmd, ref_addr,
        output wr_req, wr_end, wr_cmd, wr_addr, wr_bank, wr_data,
        output rd_req, rd_end, rd_cmd, rd_addr, rd_bank,
        input  ref_en, wr_en, rd_en,
        input  sdram_cmd, sdram_addr, sdram_bank, sdram_dq_out, sdram_dq_oe,
        input  arb_err
    );
endinterface

// File: rtl/sdram_arbit.sv
// SDRAM command arbiter: fixed priority refresh > write > read, no preemption.
// Optional grant watchdog enabled by defining SDRAM_ARBIT_WDT_EN.
module sdram_arbit (
    input  logic         sclk,
    input  logic         s_rst_n,
    sdram_arbit_if.slave bus
);

    typedef enum logic [4:0] {
        S_INIT  = 5'b00001,
        S_ARBIT = 5'b00010,
        S_AREF  = 5'b00100,
        S_WRITE = 5'b01000,
        S_READ  = 5'b10000
    } state_t;

    localparam logic [3:0] CMD_NOP = 4'b0111;

    state_t      r_state;
    state_t      w_next;
    logic        w_wdt_to;
    logic        w_ref_en;
    logic        w_wr_en;
    logic        w_rd_en;
    logic [3:0]  w_cmd;
    logic [11:0] w_addr;
    logic [1:0]  w_bank;
    logic        w_oe;

`ifdef SDRAM_ARBIT_WDT_EN
    logic [11:0] r_wdt_cnt;
    logic        r_arb_err;
    logic        w_granted;
    logic        w_own_end;

    assign w_granted = (r_state == S_AREF) || (r_state == S_WRITE) || (r_state == S_READ);
    assign w_own_end = ((r_state == S_AREF)  && bus.ref_end) ||
                       ((r_state == S_WRITE) && bus.wr_end)  ||
                       ((r_state == S_READ)  && bus.rd_end);
    // Timeout only when the owner has not ended in the same cycle the count saturates.
    assign w_wdt_to  = w_granted && (r_wdt_cnt == '1) && !w_own_end;

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_wdt_cnt <= '0;
            r_arb_err <= 1'b0;
        end else begin
            r_arb_err <= w_wdt_to;
            if (w_granted && !w_wdt_to)
                r_wdt_cnt <= r_wdt_cnt + 12'd1;
            else
                r_wdt_cnt <= '0;
        end
    end

    assign bus.arb_err = r_arb_err;
`else
    assign w_wdt_to    = 1'b0;
    assign bus.arb_err = 1'b0;
`endif

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n)
            r_state <= S_INIT;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT:  if (bus.init_end) w_next = S_ARBIT;
            S_ARBIT: begin
                if (bus.ref_req)     w_next = S_AREF;
                else if (bus.wr_req) w_next = S_WRITE;
                else if (bus.rd_req) w_next = S_READ;
            end
            S_AREF:  if (bus.ref_end || w_wdt_to) w_next = S_ARBIT;
            S_WRITE: if (bus.wr_end  || w_wdt_to) w_next = S_ARBIT;
            S_READ:  if (bus.rd_end  || w_wdt_to) w_next = S_ARBIT;
            default: w_next = S_INIT;
        endcase
    end

    always_comb begin
        w_ref_en = 1'b0;
        w_wr_en  = 1'b0;
        w_rd_en  = 1'b0;
        w_cmd    = CMD_NOP;
        w_addr   = '0;
        w_bank   = '0;
        w_oe     = 1'b0;
        case (r_state)
            S_INIT: begin
                w_cmd  = bus.init_cmd;
                w_addr = bus.init_addr;
            end
            S_AREF: begin
                w_ref_en = 1'b1;
                w_cmd    = bus.ref_cmd;
                w_addr   = bus.ref_addr;
            end
            S_WRITE: begin
                w_wr_en = 1'b1;
                w_cmd   = bus.wr_cmd;
                w_addr  = bus.wr_addr;
                w_bank  = bus.wr_bank;
                w_oe    = 1'b1;
            end
            S_READ: begin
                w_rd_en = 1'b1;
                w_cmd   = bus.rd_cmd;
                w_addr  = bus.rd_addr;
                w_bank  = bus.rd_bank;
            end
            default: ;
        endcase
    end

    assign bus.ref_en       = w_ref_en;
    assign bus.wr_en        = w_wr_en;
    assign bus.rd_en        = w_rd_en;
    assign bus.sdram_cmd    = w_cmd;
    assign bus.sdram_addr   = w_addr;
    assign bus.sdram_bank   = w_bank;
    assign bus.sdram_dq_out = bus.wr_data;
    assign bus.sdram_dq_oe  = w_oe;

endmodule

// File: tb/tb_sdram_arbit.sv
// Scoreboard bench for sdram_arbit: stimulus queues expected outputs, a negedge monitor compares.
module tb_sdram_arbit;

    localparam logic [3:0]  INIT_CMD  = 4'b0010;
    localparam logic [11:0] INIT_ADDR = 12'h400;
    localparam logic [3:0]  REF_CMD   = 4'b0001;
    localparam logic [11:0] REF_ADDR  = 12'h123;
    localparam logic [3:0]  WR_CMD    = 4'b0100;
    localparam logic [11:0] WR_ADDR   = 12'h0AB;
    localparam logic [1:0]  WR_BANK   = 2'b10;
    localparam logic [3:0]  RD_CMD    = 4'b0101;
    localparam logic [11:0] RD_ADDR   = 12'h1FF;
    localparam logic [1:0]  RD_BANK   = 2'b01;

    typedef struct {
        string       nm;
        logic [2:0]  en;
        logic [3:0]  cmd;
        logic [11:0] addr;
        logic [1:0]  bank;
        logic [15:0] dq;
        logic        oe;
        logic        err;
    } exp_t;

    logic sclk;
    logic s_rst_n;
    int   checks;
    int   errors;
    exp_t q[$];

    sdram_arbit_if bus();

    sdram_arbit dut (
        .sclk    (sclk),
        .s_rst_n (s_rst_n),
        .bus     (bus)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    task automatic push(input string nm, input logic [2:0] en, input logic [3:0] cmd,
                        input logic [11:0] addr, input logic [1:0] bank,
                        input logic oe, input logic err);
        exp_t e;
        e.nm   = nm;
        e.en   = en;
        e.cmd  = cmd;
        e.addr = addr;
        e.bank = bank;
        e.dq   = bus.wr_data;
        e.oe   = oe;
        e.err  = err;
        q.push_back(e);
    endtask

    task automatic exp_init(input string nm);
        push(nm, 3'b000, INIT_CMD, INIT_ADDR, 2'b00, 1'b0, 1'b0);
    endtask
    task automatic exp_arbit(input string nm, input logic err);
        push(nm, 3'b000, 4'b0111, 12'h000, 2'b00, 1'b0, err);
    endtask
    task automatic exp_aref(input string nm);
        push(nm, 3'b100, REF_CMD, REF_ADDR, 2'b00, 1'b0, 1'b0);
    endtask
    task automatic exp_write(input string nm);
        push(nm, 3'b010, WR_CMD, WR_ADDR, WR_BANK, 1'b1, 1'b0);
    endtask
    task automatic exp_read(input string nm);
        push(nm, 3'b001, RD_CMD, RD_ADDR, RD_BANK, 1'b0, 1'b0);
    endtask

    always @(negedge sclk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [2:0] a_en;
            e    = q.pop_front();
            a_en = {bus.ref_en, bus.wr_en, bus.rd_en};
            checks++;
            if (a_en !== e.en || bus.sdram_cmd !== e.cmd || bus.sdram_addr !== e.addr ||
                bus.sdram_bank !== e.bank || bus.sdram_dq_out !== e.dq ||
                bus.sdram_dq_oe !== e.oe || bus.arb_err !== e.err) begin
                errors++;
                $display("FAIL %s: got en=%b cmd=%b addr=%h bank=%b dq=%h oe=%b err=%b, expected en=%b cmd=%b addr=%h bank=%b dq=%h oe=%b err=%b",
                         e.nm, a_en, bus.sdram_cmd, bus.sdram_addr, bus.sdram_bank,
                         bus.sdram_dq_out, bus.sdram_dq_oe, bus.arb_err,
                         e.en, e.cmd, e.addr, e.bank, e.dq, e.oe, e.err);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        s_rst_n       = 1'b0;
        bus.init_end  = 1'b0;
        bus.init_cmd  = INIT_CMD;
        bus.init_addr = INIT_ADDR;
        bus.ref_req   = 1'b0;
        bus.ref_end   = 1'b0;
        bus.ref_cmd   = REF_CMD;
        bus.ref_addr  = REF_ADDR;
        bus.wr_req    = 1'b0;
        bus.wr_end    = 1'b0;
        bus.wr_cmd    = WR_CMD;
        bus.wr_addr   = WR_ADDR;
        bus.wr_bank   = WR_BANK;
        bus.wr_data   = 16'hA5A5;
        bus.rd_req    = 1'b0;
        bus.rd_end    = 1'b0;
        bus.rd_cmd    = RD_CMD;
        bus.rd_addr   = RD_ADDR;
        bus.rd_bank   = RD_BANK;

        step();
        exp_init("rst_init");   step();
        exp_init("rst_init2");  step();
        s_rst_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            if (i == 10) bus.init_end = 1'b1;
            exp_init("wait_init_end");
            step();
        end
        exp_arbit("arbit_idle", 1'b0); step();

        // all three requests together: refresh, one NOP, write, NOP, then read
        bus.ref_req = 1'b1; bus.wr_req = 1'b1; bus.rd_req = 1'b1;
        exp_arbit("arbit_allreq", 1'b0); step();
        exp_aref("aref_grant"); step();
        bus.ref_req = 1'b0; bus.ref_end = 1'b1;
        exp_aref("aref_end"); step();
        bus.ref_end = 1'b0;
        exp_arbit("nop_after_ref", 1'b0); step();
        exp_write("write_grant"); step();
        bus.ref_req = 1'b1; bus.rd_end = 1'b1;
        exp_write("write_no_preempt"); step();
        bus.rd_end = 1'b0; bus.ref_req = 1'b0; bus.wr_data = 16'h3C3C;
        exp_write("write_dq_pass"); step();
        bus.wr_data = 16'hA5A5; bus.wr_end = 1'b1; bus.wr_req = 1'b0;
        exp_write("write_end"); step();
        bus.wr_end = 1'b0;
        exp_arbit("nop_after_wr", 1'b0); step();
        exp_read("read_grant"); step();
        bus.ref_req = 1'b1;
        exp_read("read_no_preempt"); step();
        bus.wr_end = 1'b1; bus.ref_end = 1'b1;
        exp_read("read_spurious_end"); step();
        bus.wr_end = 1'b0; bus.ref_end = 1'b0;
        exp_read("read_hold"); step();
        bus.rd_req = 1'b0; bus.rd_end = 1'b1;
        exp_read("read_end"); step();
        bus.rd_end = 1'b0;
        exp_arbit("nop_after_rd", 1'b0); step();
        exp_aref("aref_after_rd"); step();
        bus.ref_req = 1'b0; bus.ref_end = 1'b1;
        exp_aref("aref_end2"); step();
        bus.ref_end = 1'b0;
        exp_arbit("idle_no_req", 1'b0); step();

        bus.wr_req = 1'b1; bus.rd_req = 1'b1;
        exp_arbit("wr_rd_req", 1'b0); step();
        bus.wr_req = 1'b0;
        exp_write("wr_over_rd"); step();
        bus.wr_end = 1'b1;
        exp_write("wr_end2"); step();
        bus.wr_end = 1'b0;
        exp_arbit("nop3", 1'b0); step();
        bus.rd_req = 1'b0;
        exp_read("read2"); step();

        // asynchronous reset mid-read, then wait for init_end again
        s_rst_n = 1'b0; bus.init_end = 1'b0;
        exp_init("async_rst"); step();
        exp_init("rst_hold"); step();
        s_rst_n = 1'b1;
        exp_init("post_rst_wait"); step();
        exp_init("post_rst_wait2"); step();
        bus.init_end = 1'b1;
        exp_init("post_rst_initend"); step();
        exp_arbit("post_rst_arbit", 1'b0); step();

        bus.rd_req = 1'b1;
        exp_arbit("rd_req_only", 1'b0); step();
        bus.rd_req = 1'b0;
`ifdef SDRAM_ARBIT_WDT_EN
        for (int i = 0; i < 4096; i++) begin
            exp_read("wdt_read_hold");
            step();
        end
        exp_arbit("wdt_err_pulse", 1'b1); step();
        exp_arbit("wdt_err_clear", 1'b0); step();
`else
        for (int i = 0; i < 4200; i++) begin
            exp_read("read_held");
            step();
        end
        bus.rd_end = 1'b1;
        exp_read("read_held_end"); step();
        bus.rd_end = 1'b0;
        exp_arbit("read_held_release", 1'b0); step();
`endif
        step();
        step();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
